// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// spi_flash_pkg : shared opcodes, FSM states and sync depth for spi_flash_responder
// Rev 1.0
// ============================================================================
package spi_flash_pkg;

    localparam logic [7:0] OP_READ         = 8'h03;
    localparam logic [7:0] OP_JEDEC_ID     = 8'h9F;
    localparam int         SPI_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ID     = 3'd4,
        ST_IGNORE = 3'd5
    } spi_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// ============================================================================
// spi_input_sync : 2-flop synchronizer with rise/fall detect on the synced level
// Rev 1.0
// ============================================================================
module spi_input_sync
    import spi_flash_pkg::*;
#(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SPI_SYNC_STAGES-1:0] r_chain;
    logic                       r_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {SPI_SYNC_STAGES{IDLE_VAL}};
            r_prev  <= IDLE_VAL;
        end else begin
            r_chain <= {r_chain[SPI_SYNC_STAGES-2:0], i_pin};
            r_prev  <= r_chain[SPI_SYNC_STAGES-1];
        end
    end

    assign level = r_chain[SPI_SYNC_STAGES-1];
    assign rise  =  r_chain[SPI_SYNC_STAGES-1] & ~r_prev;
    assign fall  = ~r_chain[SPI_SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// spi_flash_responder : SPI flash target serving READ (0x03) and JEDEC ID (0x9F)
// from an on-chip byte array with a backdoor load port.  Rev 1.0
// ============================================================================
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          DEPTH_BYTES = 256,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           flashClk,
    input  logic                           flashCs,
    input  logic                           flashMosi,
    output logic                           flashMiso,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_BYTES)-1:0] load_addr,
    input  logic [7:0]                     load_data,
    output logic                           busy,
    output logic                           bad_cmd
);

    localparam int AW = $clog2(DEPTH_BYTES);

    spi_resp_state_t r_state, w_state_next;

    logic          w_sck_level, w_sck_rise, w_sck_fall;
    logic          w_cs_level, w_cs_rise, w_cs_fall;
    logic          w_mosi, w_mosi_rise, w_mosi_fall;

    logic [23:0]   r_shift;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_out;
    logic [5:0]    r_bitcnt;
    logic          r_miso;
    logic          r_bad_cmd;
    logic [7:0]    r_mem [DEPTH_BYTES];

    logic [23:0]   w_shift_next;
    logic [AW-1:0] w_addr_start;
    logic [AW-1:0] w_addr_inc;
    logic          w_unused;

    spi_input_sync #(.IDLE_VAL(1'b0)) u_sync_sck (
        .clock(clock), .reset_n(reset_n), .i_pin(flashClk),
        .level(w_sck_level), .rise(w_sck_rise), .fall(w_sck_fall)
    );

    spi_input_sync #(.IDLE_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset_n(reset_n), .i_pin(flashCs),
        .level(w_cs_level), .rise(w_cs_rise), .fall(w_cs_fall)
    );

    spi_input_sync #(.IDLE_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset_n(reset_n), .i_pin(flashMosi),
        .level(w_mosi), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );

    assign w_shift_next = {r_shift[22:0], w_mosi};
    assign w_addr_start = w_shift_next[AW-1:0];
    assign w_addr_inc   = r_addr + AW'(1);
    assign w_unused     = ^{w_sck_level, w_cs_level, w_mosi_rise, w_mosi_fall, w_shift_next};

    always_ff @(posedge clock) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_next = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_sck_rise && r_bitcnt == 6'd7) begin
                        if (w_shift_next[7:0] == OP_READ) begin
                            w_state_next = ST_ADDR;
                        end else if (w_shift_next[7:0] == OP_JEDEC_ID) begin
                            w_state_next = ST_ID;
                        end else begin
                            w_state_next = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise && r_bitcnt == 6'd23) begin
                        w_state_next = ST_DATA;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_addr    <= '0;
            r_out     <= '0;
            r_bitcnt  <= '0;
            r_miso    <= 1'b0;
            r_bad_cmd <= 1'b0;
        end else if (w_cs_rise) begin
            r_miso   <= 1'b0;
            r_bitcnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_bitcnt  <= '0;
                        r_shift   <= '0;
                        r_bad_cmd <= 1'b0;
                        r_miso    <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (w_sck_rise) begin
                        r_shift  <= w_shift_next;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_bitcnt == 6'd7) begin
                            r_bitcnt <= '0;
                            // The ID stream reuses the address shifter; zeros follow the 24 ID bits.
                            if (w_shift_next[7:0] == OP_JEDEC_ID) begin
                                r_shift <= JEDEC_ID;
                            end else if (w_shift_next[7:0] != OP_READ) begin
                                r_bad_cmd <= 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise) begin
                        r_shift  <= w_shift_next;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_bitcnt == 6'd23) begin
                            r_bitcnt <= '0;
                            r_addr   <= w_addr_start;
                            r_out    <= r_mem[w_addr_start];
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sck_fall) begin
                        r_miso <= r_out[7];
                        if (r_bitcnt == 6'd7) begin
                            // Fetch on the last bit so the next byte is ready for the following fall.
                            r_bitcnt <= '0;
                            r_addr   <= w_addr_inc;
                            r_out    <= r_mem[w_addr_inc];
                        end else begin
                            r_bitcnt <= r_bitcnt + 6'd1;
                            r_out    <= {r_out[6:0], 1'b0};
                        end
                    end
                end
                ST_ID: begin
                    if (w_sck_fall) begin
                        r_miso  <= r_shift[23];
                        r_shift <= {r_shift[22:0], 1'b0};
                    end
                end
                default: begin
                    r_miso <= 1'b0;
                end
            endcase
        end
    end

    assign flashMiso = r_miso;
    assign busy      = (r_state != ST_IDLE);
    assign bad_cmd   = r_bad_cmd;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_spi_flash_responder : randomized self-checking bench against a byte-array model
// Rev 1.0
// ============================================================================
module tb_spi_flash_responder;

    localparam int DEPTH = 256;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       flashClk  = 1'b0;
    logic       flashCs   = 1'b1;
    logic       flashMosi = 1'b0;
    logic       load_en   = 1'b0;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       flashMiso;
    logic       busy;
    logic       bad_cmd;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model [DEPTH];

    always #5 clock = ~clock;

    spi_flash_responder #(
        .DEPTH_BYTES(DEPTH),
        .JEDEC_ID   (24'hEF4016)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flashClk (flashClk),
        .flashCs  (flashCs),
        .flashMosi(flashMosi),
        .flashMiso(flashMiso),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy     (busy),
        .bad_cmd  (bad_cmd)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bd_load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clock);
        load_en   = 1'b0;
        model[a]  = d;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            flashMosi = tx[7-i];
            cyc(5);
            rx = {rx[6:0], flashMiso};
            flashClk = 1'b1;
            cyc(5);
            flashClk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        flashCs = 1'b0;
        cyc(5);
    endtask

    task automatic spi_end();
        cyc(5);
        flashCs = 1'b1;
        cyc(8);
    endtask

    task automatic send_read_hdr(input logic [23:0] a);
        logic [7:0] rx;
        spi_bits(8'h03, 8, rx);
        spi_bits(a[23:16], 8, rx);
        spi_bits(a[15:8], 8, rx);
        spi_bits(a[7:0], 8, rx);
    endtask

    task automatic read_check(input string tag, input logic [23:0] a, input int nbytes, input bit poke);
        logic [7:0] rx;
        logic [7:0] exp;
        spi_begin();
        send_read_hdr(a);
        for (int k = 0; k < nbytes; k++) begin
            exp = model[(int'(a) + k) % DEPTH];
            spi_bits(8'h00, 8, rx);
            check_val($sformatf("%s_b%0d", tag, k), {24'h0, rx}, {24'h0, exp});
            check_val($sformatf("%s_busy%0d", tag, k), {31'h0, busy}, 32'h1);
            if (poke) begin
                bd_load(8'((int'(a) + k + 2) % DEPTH), 8'($urandom));
            end
        end
        spi_end();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic [23:0] ra;

        cyc(4);
        check_val("rst_busy", {31'h0, busy}, 32'h0);
        check_val("rst_miso", {31'h0, flashMiso}, 32'h0);
        check_val("rst_bad",  {31'h0, bad_cmd}, 32'h0);
        reset_n = 1'b1;
        cyc(4);

        for (int i = 0; i < DEPTH; i++) bd_load(8'(i), 8'($urandom));
        bd_load(8'd0, 8'h11);
        bd_load(8'd1, 8'h22);
        bd_load(8'd2, 8'h33);
        bd_load(8'd3, 8'h44);

        // Basic read plus busy release latency after CS rises.
        spi_begin();
        send_read_hdr(24'h000000);
        for (int k = 0; k < 4; k++) begin
            spi_bits(8'h00, 8, rx);
            check_val($sformatf("basic_b%0d", k), {24'h0, rx}, {24'h0, model[k]});
            check_val($sformatf("basic_busy%0d", k), {31'h0, busy}, 32'h1);
        end
        cyc(5);
        flashCs = 1'b1;
        cyc(2);
        check_val("busy_hold", {31'h0, busy}, 32'h1);
        cyc(1);
        check_val("busy_drop", {31'h0, busy}, 32'h0);
        check_val("miso_idle", {31'h0, flashMiso}, 32'h0);
        cyc(8);

        // Partial byte aborted by CS, then a clean restart at address 2.
        spi_begin();
        send_read_hdr(24'h000000);
        spi_bits(8'h00, 4, rx);
        spi_end();
        read_check("restart", 24'h000002, 1, 1'b0);

        // Wrap at the top of the array, with and without upper address bits.
        bd_load(8'hFF, 8'hAA);
        bd_load(8'h00, 8'h55);
        read_check("wrap", 24'h0000FF, 2, 1'b0);
        read_check("wrap_mask", 24'h1234FF, 2, 1'b0);

        // JEDEC ID followed by zeros.
        spi_begin();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h00, 8, rx); check_val("id0", {24'h0, rx}, 32'hEF);
        spi_bits(8'h00, 8, rx); check_val("id1", {24'h0, rx}, 32'h40);
        spi_bits(8'h00, 8, rx); check_val("id2", {24'h0, rx}, 32'h16);
        spi_bits(8'h00, 8, rx); check_val("id3", {24'h0, rx}, 32'h00);
        check_val("id_bad", {31'h0, bad_cmd}, 32'h0);
        spi_end();

        // Unsupported opcode.
        spi_begin();
        spi_bits(8'h0B, 8, rx);
        check_val("bad_set", {31'h0, bad_cmd}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            spi_bits(8'hFF, 8, rx);
            check_val($sformatf("bad_miso%0d", k), {24'h0, rx}, 32'h0);
        end
        spi_end();
        check_val("bad_sticky", {31'h0, bad_cmd}, 32'h1);
        flashCs = 1'b0;
        cyc(5);
        check_val("bad_clear", {31'h0, bad_cmd}, 32'h0);
        flashCs = 1'b1;
        cyc(8);

        // Random reads with backdoor writes to bytes not yet fetched.
        for (int t = 0; t < 8; t++) begin
            ra = 24'($urandom);
            read_check($sformatf("rnd%0d", t), ra, int'($urandom_range(1, 4)), t[0]);
        end

        // Asynchronous reset in the middle of a data byte.
        bd_load(8'd10, 8'hFF);
        spi_begin();
        send_read_hdr(24'h00000A);
        spi_bits(8'h00, 4, rx);
        cyc(4);
        check_val("pre_rst_miso", {31'h0, flashMiso}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_miso", {31'h0, flashMiso}, 32'h0);
        check_val("arst_busy", {31'h0, busy}, 32'h0);
        check_val("arst_bad",  {31'h0, bad_cmd}, 32'h0);
        flashCs  = 1'b1;
        flashClk = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(4);
        read_check("post_rst", 24'h000000, 4, 1'b0);
        read_check("post_rst10", 24'h00000A, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
